// File: rtl/if_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// The byte-wide memory bus and the fetch FSM encoding live here.
package if_fetch_pkg;

  localparam int unsigned AddrW = 32;
  localparam int unsigned InstW = 32;
  localparam int unsigned ByteW = 8;

  typedef logic [AddrW-1:0] addr_t;
  typedef logic [InstW-1:0] inst_t;
  typedef logic [ByteW-1:0] byte_t;

  localparam addr_t Zero32 = '0;
  localparam addr_t PcStep = 32'd4;

  typedef enum logic [2:0] {
    StS0   = 3'd0,
    StS1   = 3'd1,
    StS2   = 3'd2,
    StS3   = 3'd3,
    StS4   = 3'd4,
    StHold = 3'd5
  } fetch_state_e;

endpackage

// File: rtl/if_fetch_if.sv
// Byte-wide synchronous instruction-memory bus: address/read-enable out, data back
// one cycle after the address.
interface if_fetch_if;
  import if_fetch_pkg::*;

  addr_t mem_a;
  logic  mem_re;
  byte_t mem_din;

  modport master (output mem_a, output mem_re, input mem_din);
  modport slave  (input mem_a, input mem_re, output mem_din);

endinterface

// File: rtl/if_fetch.sv
// Instruction fetch: assembles one 32-bit instruction from four byte reads and
// presents {pc, inst, valid} to IF/ID, honouring stall and branch redirect.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              branch_flag,
  input  addr_t             branch_target,
  if_fetch_if.master        mem,
  output addr_t             if_pc,
  output inst_t             if_inst,
  output logic              if_valid
);

  fetch_state_e state_q, state_d;
  addr_t        pc_q, pc_d;
  byte_t        b0_q, b0_d, b1_q, b1_d, b2_q, b2_d;
  addr_t        if_pc_q, if_pc_d;
  inst_t        if_inst_q, if_inst_d;
  logic         if_valid_q, if_valid_d;

  addr_t        mem_a;
  logic         mem_re;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    b0_d       = b0_q;
    b1_d       = b1_q;
    b2_d       = b2_q;
    if_pc_d    = if_pc_q;
    if_inst_d  = if_inst_q;
    if_valid_d = if_valid_q;

    if (branch_flag) begin
      // Redirect wins over stall and over an instruction completing in S4.
      state_d    = StS0;
      pc_d       = branch_target;
      if_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        StS0: state_d = StS1;
        StS1: begin
          b0_d    = mem.mem_din;
          state_d = StS2;
        end
        StS2: begin
          b1_d    = mem.mem_din;
          state_d = StS3;
        end
        StS3: begin
          b2_d    = mem.mem_din;
          state_d = StS4;
        end
        StS4: begin
          if_inst_d  = {mem.mem_din, b2_q, b1_q, b0_q};
          if_pc_d    = pc_q;
          if_valid_d = 1'b1;
          pc_d       = pc_q + PcStep;
          state_d    = StHold;
        end
        StHold: begin
          // The S0 address issue is folded into HOLD on release.
          if (!stall) begin
            if_valid_d = 1'b0;
            state_d    = StS1;
          end
        end
        default: state_d = StS0;
      endcase
    end
  end

  always_comb begin
    mem_a  = pc_q;
    mem_re = 1'b0;
    if (!rst && !branch_flag) begin
      unique case (state_q)
        StS0:   mem_re = 1'b1;
        StS1: begin
          mem_a  = pc_q + 32'd1;
          mem_re = 1'b1;
        end
        StS2: begin
          mem_a  = pc_q + 32'd2;
          mem_re = 1'b1;
        end
        StS3: begin
          mem_a  = pc_q + 32'd3;
          mem_re = 1'b1;
        end
        StHold: mem_re = !stall;
        default: mem_re = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StS0;
      pc_q       <= RESET_PC;
      b0_q       <= '0;
      b1_q       <= '0;
      b2_q       <= '0;
      if_pc_q    <= Zero32;
      if_inst_q  <= Zero32;
      if_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      b0_q       <= b0_d;
      b1_q       <= b1_d;
      b2_q       <= b2_d;
      if_pc_q    <= if_pc_d;
      if_inst_q  <= if_inst_d;
      if_valid_q <= if_valid_d;
    end
  end

  assign mem.mem_a  = mem_a;
  assign mem.mem_re = mem_re;
  assign if_pc      = if_pc_q;
  assign if_inst    = if_inst_q;
  assign if_valid   = if_valid_q;

endmodule

// File: tb/tb_if_fetch.sv
// Cycle-by-cycle vector bench for if_fetch with a byte-wide synchronous memory model.
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rst2 = 1'b1;
  logic        stall = 1'b0;
  logic        branch_flag = 1'b0;
  logic [31:0] branch_target = '0;
  logic [31:0] if_pc, if_pc2;
  logic [31:0] if_inst, if_inst2;
  logic        if_valid, if_valid2;

  int total = 0;
  int bad = 0;

  if_fetch_if bus1 ();
  if_fetch_if bus2 ();

  if_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .branch_flag   (branch_flag),
    .branch_target (branch_target),
    .mem           (bus1),
    .if_pc         (if_pc),
    .if_inst       (if_inst),
    .if_valid      (if_valid)
  );

  if_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk           (clk),
    .rst           (rst2),
    .stall         (1'b0),
    .branch_flag   (1'b0),
    .branch_target (32'h0),
    .mem           (bus2),
    .if_pc         (if_pc2),
    .if_inst       (if_inst2),
    .if_valid      (if_valid2)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    case (a)
      32'h0:   return 8'h13;
      32'h1:   return 8'h05;
      32'h2:   return 8'h10;
      32'h3:   return 8'h00;
      default: return a[7:0] ^ a[31:24] ^ 8'h5A;
    endcase
  endfunction

  function automatic logic [31:0] inst_at(input logic [31:0] pc);
    return {mem_byte(pc + 32'd3), mem_byte(pc + 32'd2), mem_byte(pc + 32'd1), mem_byte(pc)};
  endfunction

  always @(posedge clk) begin
    if (bus1.mem_re) bus1.mem_din <= mem_byte(bus1.mem_a);
    if (bus2.mem_re) bus2.mem_din <= mem_byte(bus2.mem_a);
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  typedef struct {
    logic        stall;
    logic        br;
    logic [31:0] tgt;
    logic        re;
    logic [31:0] a;
    logic        v;
    logic [31:0] pc;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic s, input logic b, input logic [31:0] t, input logic re,
                     input logic [31:0] a, input logic v, input logic [31:0] pc);
    vec_t x;
    x.stall = s;
    x.br    = b;
    x.tgt   = t;
    x.re    = re;
    x.a     = a;
    x.v     = v;
    x.pc    = pc;
    vecs.push_back(x);
  endtask

  logic [31:0] exp_a2[4];

  initial begin
    // stall, branch, target | mem_re, mem_a (checked when re=1), valid, pc (when valid)
    add(0, 0, 0,      1, 32'h000, 0, 0);      // c0  S0
    add(0, 0, 0,      1, 32'h001, 0, 0);
    add(0, 0, 0,      1, 32'h002, 0, 0);
    add(0, 0, 0,      1, 32'h003, 0, 0);
    add(0, 0, 0,      0, 32'h000, 0, 0);      // c4  S4
    add(0, 0, 0,      1, 32'h004, 1, 32'h0);  // c5  first instruction valid
    add(0, 0, 0,      1, 32'h005, 0, 0);
    add(0, 0, 0,      1, 32'h006, 0, 0);
    add(0, 0, 0,      1, 32'h007, 0, 0);
    add(0, 0, 0,      0, 32'h000, 0, 0);
    add(0, 0, 0,      1, 32'h008, 1, 32'h4);  // c10
    add(0, 0, 0,      1, 32'h009, 0, 0);
    add(0, 0, 0,      1, 32'h00A, 0, 0);
    add(0, 0, 0,      1, 32'h00B, 0, 0);
    add(0, 0, 0,      0, 32'h000, 0, 0);
    add(1, 0, 0,      0, 32'h000, 1, 32'h8);  // c15 stall in HOLD
    add(1, 0, 0,      0, 32'h000, 1, 32'h8);
    add(1, 0, 0,      0, 32'h000, 1, 32'h8);
    add(0, 0, 0,      1, 32'h00C, 1, 32'h8);  // release: next fetch at pc+4
    add(0, 0, 0,      1, 32'h00D, 0, 0);
    add(0, 1, 32'h100, 0, 32'h000, 0, 0);     // c20 branch in S2
    add(0, 0, 0,      1, 32'h100, 0, 0);
    add(0, 0, 0,      1, 32'h101, 0, 0);
    add(0, 0, 0,      1, 32'h102, 0, 0);
    add(0, 0, 0,      1, 32'h103, 0, 0);
    add(0, 0, 0,      0, 32'h000, 0, 0);
    add(0, 0, 0,      1, 32'h104, 1, 32'h100); // c26 = branch + 6
    add(0, 0, 0,      1, 32'h105, 0, 0);
    add(0, 0, 0,      1, 32'h106, 0, 0);
    add(0, 0, 0,      1, 32'h107, 0, 0);
    add(1, 1, 32'h200, 0, 32'h000, 0, 0);     // c30 branch+stall in S4
    add(1, 0, 0,      1, 32'h200, 0, 0);      // stall ignored in S0
    add(0, 0, 0,      1, 32'h201, 0, 0);
    add(0, 0, 0,      1, 32'h202, 0, 0);
    add(0, 0, 0,      1, 32'h203, 0, 0);
    add(0, 0, 0,      0, 32'h000, 0, 0);
    add(1, 0, 0,      0, 32'h000, 1, 32'h200);
    add(0, 0, 0,      1, 32'h204, 1, 32'h200);
    add(0, 0, 0,      1, 32'h205, 0, 0);

    repeat (2) @(negedge clk);
    #1;
    check("reset mem_re", {31'b0, bus1.mem_re}, 32'h0);
    check("reset if_valid", {31'b0, if_valid}, 32'h0);
    check("reset if_pc", if_pc, 32'h0);
    check("reset if_inst", if_inst, 32'h0);

    @(negedge clk);
    rst = 1'b0;
    foreach (vecs[i]) begin
      stall         = vecs[i].stall;
      branch_flag   = vecs[i].br;
      branch_target = vecs[i].tgt;
      #1;
      check($sformatf("c%0d mem_re", i), {31'b0, bus1.mem_re}, {31'b0, vecs[i].re});
      if (vecs[i].re) check($sformatf("c%0d mem_a", i), bus1.mem_a, vecs[i].a);
      check($sformatf("c%0d if_valid", i), {31'b0, if_valid}, {31'b0, vecs[i].v});
      if (vecs[i].v) begin
        check($sformatf("c%0d if_pc", i), if_pc, vecs[i].pc);
        check($sformatf("c%0d if_inst", i), if_inst, inst_at(vecs[i].pc));
      end
      @(negedge clk);
    end
    stall       = 1'b0;
    branch_flag = 1'b0;

    // Reset mid-fetch: everything discarded, restart at RESET_PC.
    rst = 1'b1;
    #1;
    check("midreset mem_re", {31'b0, bus1.mem_re}, 32'h0);
    @(negedge clk);
    #1;
    check("midreset if_valid", {31'b0, if_valid}, 32'h0);
    check("midreset if_pc", if_pc, 32'h0);
    check("midreset if_inst", if_inst, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("restart mem_a", bus1.mem_a, 32'h0);
    check("restart mem_re", {31'b0, bus1.mem_re}, 32'h1);
    repeat (5) @(negedge clk);
    #1;
    check("restart if_valid", {31'b0, if_valid}, 32'h1);
    check("restart if_inst", if_inst, 32'h0010_0513);
    check("restart if_pc", if_pc, 32'h0);

    // Address wrap from RESET_PC = FFFF_FFFC.
    exp_a2[0] = 32'hFFFF_FFFC;
    exp_a2[1] = 32'hFFFF_FFFD;
    exp_a2[2] = 32'hFFFF_FFFE;
    exp_a2[3] = 32'hFFFF_FFFF;
    @(negedge clk);
    rst2 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      check($sformatf("wrap mem_a%0d", k), bus2.mem_a, exp_a2[k]);
      check($sformatf("wrap mem_re%0d", k), {31'b0, bus2.mem_re}, 32'h1);
      @(negedge clk);
    end
    #1;
    check("wrap s4 mem_re", {31'b0, bus2.mem_re}, 32'h0);
    @(negedge clk);
    #1;
    check("wrap if_valid", {31'b0, if_valid2}, 32'h1);
    check("wrap if_pc", if_pc2, 32'hFFFF_FFFC);
    check("wrap if_inst", if_inst2, inst_at(32'hFFFF_FFFC));
    check("wrap next mem_a", bus2.mem_a, 32'h0);
    check("wrap next mem_re", {31'b0, bus2.mem_re}, 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
